fifo_wr_arbiter: RTL and testbench
==================================

Name: fifo_wr_arbiter

Overview:
- Shares the single 8-deep, 8-bit FIFO write port between NUM_REQ producers.
- Round-robin grant with a bounded burst length per grant.
- Drives the FIFO's write strobe and data from a registered output stage.
- Tracks FIFO occupancy, including its own in-flight write, so no word is ever dropped on full.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, data width; matches the FIFO data width.
- DEPTH, 8, FIFO capacity in words.
- CNT_W, 4, width of the FIFO occupancy counter input.
- BURST_MAX, 2, maximum words accepted per grant (1..15).
- HIGH_WM, 6, grant-inhibit threshold; used only with the optional feature.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester request; level, held while data is valid
- req_data  in  NUM_REQ*DATA_W  requester i data at bits [i*DATA_W +: DATA_W]
- gnt  out  NUM_REQ  registered one-hot grant; all zero when idle
- ack  out  NUM_REQ  combinational; ack[i]=1 when requester i's word is accepted this cycle
- fifo_count  in  CNT_W  FIFO occupancy counter
- fifo_full  in  1  FIFO full flag
- fifo_wr  out  1  registered write strobe to the FIFO
- fifo_din  out  DATA_W  registered write data to the FIFO

Behaviour:
- Reset: state=IDLE, gnt=0, fifo_wr=0, fifo_din=0, rr_ptr=0, burst_cnt=0. While rst is high, ack=0 and nothing is accepted.
- space = !fifo_full && (fifo_count + fifo_wr < DEPTH). Compute the sum at CNT_W+1 bits so it cannot overflow.
- FSM has two states, IDLE and SERVE.
- IDLE:
  - If any req and space: winner = first set req scanning from rr_ptr upward, with wrap.
  - Next cycle: gnt=onehot(winner), state=SERVE, burst_cnt=0.
  - No acceptance happens in IDLE.
- SERVE:
  - accept = gnt[i] && req[i] && space && !rst. On accept, ack[i]=1.
  - The next cycle has fifo_wr=1 and fifo_din=req_data[i], giving 1-cycle latency. burst_cnt increments.
  - If gnt[i] && req[i] && !space: hold the grant and stall. Nothing is accepted and burst_cnt is unchanged.
  - Release the grant when the accept makes burst_cnt reach BURST_MAX, or when req[i] is low. On release: gnt=0, rr_ptr=(i+1) mod NUM_REQ, state=IDLE.
  - Each release costs exactly one bubble cycle before the next grant.
- fifo_wr is low in any cycle not preceded by an accept. fifo_din holds its last value when fifo_wr=0.
- The arbiter never writes when space=0, so the FIFO never sees a write while full. The arbiter never asserts a FIFO read.
- A requester dropping req mid-burst loses nothing; the words already acked are committed.
- Reset mid-burst: the grant drops the next cycle and fifo_wr clears. A word acked in the cycle before rst still appears on fifo_wr in the rst cycle; the FIFO reset owns its fate.
- Fairness: with all req high, grants rotate 0,1,2,3,0,... Each grant gets at most BURST_MAX words.

Optional Feature:
- Macro: FIFO_ARB_WATERMARK_EN.
- Defined: IDLE issues no new grant while fifo_count >= HIGH_WM. A burst already in SERVE continues, governed only by space.
- Undefined: the grant decision uses space only, and HIGH_WM is ignored.

Decomposition:
- Package fifo_arb_pkg holds:
  - the state enum {IDLE, SERVE};
  - the default DATA_W, DEPTH and CNT_W constants;
  - the one-hot/index conversion functions.
- Sub-module fifo_rr_picker: combinational round-robin picker with inputs req and rr_ptr and outputs the winner index and a valid flag. It is reused for any future read-side scheduler.

Test Plan:
- Reset: rst high for 2 cycles with req=4'b1111 -> gnt=0, fifo_wr=0, ack=0. First grant is gnt=4'b0001, 1 cycle after rst falls.
- Round robin: all req high, fifo_count=0, data 0xA0..0xA3, BURST_MAX=2 -> fifo_din sequence A0,A0,A1,A1,A2,A2,A3,A3. Each pair is separated by one fifo_wr=0 bubble.
- Full stall: fifo_count=7, one requester pushing -> exactly one more write. Hold fifo_count=8 -> gnt held, ack=0, fifo_wr=0. Drop fifo_count to 6 -> writes resume with no lost or duplicated word.
- In-flight space: fifo_count=7 and fifo_wr=1 in the same cycle -> no ack that cycle.
- Early release: requester 2 granted, drops req after 1 word -> gnt=0 next cycle, rr_ptr=3, next grant goes to req[3] if set, else req[0].
- Watermark (FIFO_ARB_WATERMARK_EN, HIGH_WM=6): fifo_count=6 with req pending -> no grant. fifo_count=5 -> grant issued.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types, default sizes and one-hot helpers for the FIFO write arbiter
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SERVE = 1'b1
  } arb_state_t;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_CNT_W  = 4;

  // Widest requester vector the helpers handle; callers size-cast in and out.
  localparam int MAX_REQ   = 8;
  localparam int MAX_IDX_W = 3;

  function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [MAX_IDX_W-1:0] idx);
    logic [MAX_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

  // OR-reduction encoder; the result is only meaningful for a one-hot input.
  function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [MAX_IDX_W-1:0] idx;
    idx = '0;
    for (int k = 0; k < MAX_REQ; k++) begin
      if (oh[k]) idx = idx | MAX_IDX_W'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/fifo_rr_picker.sv
// rtl/fifo_rr_picker.sv - combinational round-robin picker: first set request at or after rr_ptr, with wrap
module fifo_rr_picker
  #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
  )
  (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   winner,
    output logic               valid
  );

  // Unrolled per pointer value so every request select is a constant index;
  // scanning offsets downward lets the closest request to rr_ptr win last.
  always_comb begin
    winner = '0;
    valid  = 1'b0;
    for (int p = 0; p < NUM_REQ; p++) begin
      if (rr_ptr == IDX_W'(p)) begin
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
          if (req[(p + k) % NUM_REQ]) begin
            winner = IDX_W'((p + k) % NUM_REQ);
            valid  = 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter for one FIFO write port (option: FIFO_ARB_WATERMARK_EN)
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
  #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int CNT_W     = DEF_CNT_W,
    parameter int BURST_MAX = 2,
    parameter int HIGH_WM   = 6
  )
  (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [NUM_REQ-1:0]        ack,
    input  logic [CNT_W-1:0]          fifo_count,
    input  logic                      fifo_full,
    output logic                      fifo_wr,
    output logic [DATA_W-1:0]         fifo_din
  );

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t        state;
  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_valid;
  logic [IDX_W-1:0]  cur_idx;
  logic [3:0]        burst_cnt;
  logic [CNT_W:0]    occ_sum;
  logic              space;
  logic              grant_ok;
  logic              cur_req;
  logic [DATA_W-1:0] cur_data;
  logic              accept;
  logic              burst_done;
  logic              release_now;

  // Occupancy includes the write already sitting in the output register.
  assign occ_sum = {1'b0, fifo_count} + {{CNT_W{1'b0}}, fifo_wr};
  assign space   = !fifo_full && (occ_sum < (CNT_W+1)'(DEPTH));

`ifdef FIFO_ARB_WATERMARK_EN
  // Near-full FIFO: let running bursts drain on space alone, but start no new ones.
  assign grant_ok = space && (fifo_count < CNT_W'(HIGH_WM));
`else
  assign grant_ok = space;
`endif

  fifo_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .winner  (pick_idx),
    .valid   (pick_valid)
  );

  // Select the current grant holder's request and data.
  always_comb begin
    cur_req  = 1'b0;
    cur_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        cur_req  = req[k];
        cur_data = req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign cur_idx     = IDX_W'(onehot_to_idx(MAX_REQ'(gnt)));
  assign accept      = (state == SERVE) && cur_req && space && !rst;
  assign ack         = accept ? gnt : '0;
  assign burst_done  = accept && (burst_cnt == 4'(BURST_MAX - 1));
  assign release_now = (state == SERVE) && (burst_done || !cur_req);

  // Grant FSM plus the registered write stage; an accepted word is written one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      fifo_wr   <= 1'b0;
      fifo_din  <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      fifo_wr <= accept;
      if (accept) begin
        fifo_din  <= cur_data;
        burst_cnt <= burst_cnt + 4'd1;
      end
      case (state)
        IDLE: begin
          if (pick_valid && grant_ok) begin
            gnt       <= NUM_REQ'(idx_to_onehot(MAX_IDX_W'(pick_idx)));
            burst_cnt <= '0;
            state     <= SERVE;
          end
        end
        SERVE: begin
          if (release_now) begin
            gnt    <= '0;
            rr_ptr <= (cur_idx == IDX_W'(NUM_REQ - 1)) ? '0 : cur_idx + 1'b1;
            state  <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench: directed vector table, watermark sequence, randomized model run
module tb_fifo_wr_arbiter;

  localparam int NR    = 4;
  localparam int DW    = 8;
  localparam int BMAX  = 2;
  localparam int DEPTH = 8;
  localparam int HWM   = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    gnt;
  logic [NR-1:0]    ack;
  logic [3:0]       fifo_count;
  logic             fifo_full;
  logic             fifo_wr;
  logic [DW-1:0]    fifo_din;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(
    .NUM_REQ   (NR),
    .DATA_W    (DW),
    .DEPTH     (DEPTH),
    .CNT_W     (4),
    .BURST_MAX (BMAX),
    .HIGH_WM   (HWM)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .gnt        (gnt),
    .ack        (ack),
    .fifo_count (fifo_count),
    .fifo_full  (fifo_full),
    .fifo_wr    (fifo_wr),
    .fifo_din   (fifo_din)
  );

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic [3:0] cnt;
    logic       full;
    logic [3:0] e_gnt;
    logic [3:0] e_ack;
    logic       e_wr;
    logic [7:0] e_din;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [3:0] c, input logic f,
                              input logic [3:0] g, input logic [3:0] a, input logic w, input logic [7:0] d);
    vec_t v;
    v.rst = r; v.req = rq; v.cnt = c; v.full = f;
    v.e_gnt = g; v.e_ack = a; v.e_wr = w; v.e_din = d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model state for the random run
  bit          m_serve;
  int          m_owner;
  int          m_ptr;
  int          m_burst;
  bit          m_wr;
  int          fcount;
  logic [7:0]  sb[$];

  initial begin
    bit          r_rst;
    bit          rd;
    bit          sp;
    bit          acc;
    bit          wr_now;
    bit          wm_ok;
    bit          found;
    logic [3:0]  rqv;
    logic [7:0]  exp_word;
    int          win;

    // Directed table: one row per cycle; data fixed at A0..A3.
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    //                 rst  req   cnt  full gnt   ack   wr  din
    tbl.push_back(mk(1, 4'hF, 4'd0, 0, 4'h0, 4'h0, 0, 8'h00));
    tbl.push_back(mk(0, 4'hF, 4'd0, 0, 4'h0, 4'h0, 0, 8'h00));
    tbl.push_back(mk(0, 4'hF, 4'd0, 0, 4'h1, 4'h1, 0, 8'h00));
    tbl.push_back(mk(0, 4'hF, 4'd0, 0, 4'h1, 4'h1, 1, 8'hA0));
    tbl.push_back(mk(0, 4'hF, 4'd0, 0, 4'h0, 4'h0, 1, 8'hA0));
    tbl.push_back(mk(0, 4'hF, 4'd0, 0, 4'h2, 4'h2, 0, 8'hA0));
    tbl.push_back(mk(0, 4'hF, 4'd0, 0, 4'h2, 4'h2, 1, 8'hA1));
    tbl.push_back(mk(0, 4'hF, 4'd0, 0, 4'h0, 4'h0, 1, 8'hA1));
    tbl.push_back(mk(0, 4'hF, 4'd0, 0, 4'h4, 4'h4, 0, 8'hA1));
    tbl.push_back(mk(0, 4'hF, 4'd0, 0, 4'h4, 4'h4, 1, 8'hA2));
    tbl.push_back(mk(0, 4'hF, 4'd0, 0, 4'h0, 4'h0, 1, 8'hA2));
    tbl.push_back(mk(0, 4'hF, 4'd0, 0, 4'h8, 4'h8, 0, 8'hA2));
    tbl.push_back(mk(0, 4'hF, 4'd0, 0, 4'h8, 4'h8, 1, 8'hA3));
    tbl.push_back(mk(0, 4'hF, 4'd0, 0, 4'h0, 4'h0, 1, 8'hA3));
    // full stall and in-flight space with requester 0 alone
    tbl.push_back(mk(0, 4'h1, 4'd7, 0, 4'h1, 4'h1, 0, 8'hA3));
    tbl.push_back(mk(0, 4'h1, 4'd7, 0, 4'h1, 4'h0, 1, 8'hA0));
    tbl.push_back(mk(0, 4'h1, 4'd8, 1, 4'h1, 4'h0, 0, 8'hA0));
    tbl.push_back(mk(0, 4'h1, 4'd8, 1, 4'h1, 4'h0, 0, 8'hA0));
    tbl.push_back(mk(0, 4'h1, 4'd6, 0, 4'h1, 4'h1, 0, 8'hA0));
    tbl.push_back(mk(0, 4'h1, 4'd7, 0, 4'h0, 4'h0, 1, 8'hA0));
    tbl.push_back(mk(0, 4'h1, 4'd7, 0, 4'h0, 4'h0, 0, 8'hA0));
    // early release: requester 2 takes one word then drops req
    tbl.push_back(mk(0, 4'h4, 4'd0, 0, 4'h1, 4'h0, 0, 8'hA0));
    tbl.push_back(mk(0, 4'h4, 4'd0, 0, 4'h0, 4'h0, 0, 8'hA0));
    tbl.push_back(mk(0, 4'h4, 4'd0, 0, 4'h4, 4'h4, 0, 8'hA0));
    tbl.push_back(mk(0, 4'h9, 4'd0, 0, 4'h4, 4'h0, 1, 8'hA2));
    tbl.push_back(mk(0, 4'h9, 4'd0, 0, 4'h0, 4'h0, 0, 8'hA2));
    tbl.push_back(mk(0, 4'h9, 4'd0, 0, 4'h8, 4'h8, 0, 8'hA2));
    // reset mid-burst: word acked just before rst still shows in the rst cycle
    tbl.push_back(mk(1, 4'h9, 4'd0, 0, 4'h8, 4'h0, 1, 8'hA3));
    tbl.push_back(mk(0, 4'h1, 4'd0, 0, 4'h0, 4'h0, 0, 8'h00));
    tbl.push_back(mk(0, 4'h0, 4'd0, 0, 4'h1, 4'h0, 0, 8'h00));
    tbl.push_back(mk(0, 4'h0, 4'd0, 0, 4'h0, 4'h0, 0, 8'h00));
    tbl.push_back(mk(0, 4'h0, 4'd0, 0, 4'h0, 4'h0, 0, 8'h00));

    rst = 1'b1; req = 4'hF; fifo_count = 4'd0; fifo_full = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].rst; req = tbl[i].req; fifo_count = tbl[i].cnt; fifo_full = tbl[i].full;
      #1;
      chk($sformatf("vec%0d_gnt", i), 32'(gnt), 32'(tbl[i].e_gnt));
      chk($sformatf("vec%0d_ack", i), 32'(ack), 32'(tbl[i].e_ack));
      chk($sformatf("vec%0d_wr", i), 32'(fifo_wr), 32'(tbl[i].e_wr));
      chk($sformatf("vec%0d_din", i), 32'(fifo_din), 32'(tbl[i].e_din));
      @(posedge clk); #1;
    end

    // Watermark sequence: arbiter idle with rr_ptr=1, requester 1 asks at count 6.
    req = 4'h2; fifo_count = 4'd6; fifo_full = 1'b0;
    #1;
    chk("wm_idle_ack", 32'(ack), 32'h0);
    @(posedge clk); #1;
`ifdef FIFO_ARB_WATERMARK_EN
    chk("wm_inhibit_gnt", 32'(gnt), 32'h0);
    fifo_count = 4'd5;
    @(posedge clk); #1;
    chk("wm_resume_gnt", 32'(gnt), 32'h2);
`else
    chk("wm_off_gnt", 32'(gnt), 32'h2);
`endif

    // Randomized run with a small FIFO occupancy model and a word scoreboard.
    req = 4'h0; rst = 1'b1; fifo_count = 4'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    m_serve = 0; m_owner = 0; m_ptr = 0; m_burst = 0; m_wr = 0; fcount = 0;
    rqv = 4'h0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      chk("rnd_gnt", 32'(gnt), m_serve ? (32'd1 << m_owner) : 32'd0);
      chk("rnd_wr", 32'(fifo_wr), 32'(m_wr));
      if (fifo_wr) begin
        chk("rnd_wr_not_full", 32'(fcount < DEPTH), 32'd1);
        if (sb.size() == 0) begin
          chk("rnd_sb_empty", 32'd1, 32'd0);
        end else begin
          exp_word = sb.pop_front();
          chk("rnd_din", 32'(fifo_din), 32'(exp_word));
        end
      end

      r_rst = ($urandom_range(0, 199) == 0);
      rqv   = rqv ^ 4'($urandom & $urandom);
      rd    = (fcount > 0) && ($urandom_range(0, 2) == 0);
      rst = r_rst; req = rqv; req_data = 32'($urandom);
      fifo_count = 4'(fcount); fifo_full = (fcount == DEPTH);
      #1;

      sp  = (fcount != DEPTH) && (fcount + int'(m_wr) < DEPTH);
      acc = !r_rst && m_serve && rqv[m_owner] && sp;
      chk("rnd_ack", 32'(ack), acc ? (32'd1 << m_owner) : 32'd0);
      if (acc) sb.push_back(req_data[m_owner*DW +: DW]);
      wr_now = fifo_wr;

`ifdef FIFO_ARB_WATERMARK_EN
      wm_ok = (fcount < HWM);
`else
      wm_ok = 1'b1;
`endif
      if (r_rst) begin
        m_serve = 0; m_ptr = 0; m_burst = 0; m_wr = 0;
      end else begin
        m_wr = acc;
        if (!m_serve) begin
          found = 0; win = 0;
          for (int k = 0; k < NR; k++) begin
            if (!found && rqv[(m_ptr + k) % NR]) begin
              found = 1; win = (m_ptr + k) % NR;
            end
          end
          if (found && sp && wm_ok) begin
            m_serve = 1; m_owner = win; m_burst = 0;
          end
        end else if (acc) begin
          m_burst++;
          if (m_burst == BMAX) begin
            m_serve = 0; m_ptr = (m_owner + 1) % NR;
          end
        end else if (!rqv[m_owner]) begin
          m_serve = 0; m_ptr = (m_owner + 1) % NR;
        end
      end

      @(posedge clk); #1;
      fcount = fcount + int'(wr_now) - int'(rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
